round_key: RTL and testbench
============================

Name: round_key

Overview:
- Registered DES key-schedule generator for the Triple-DES datapath.
- Expands a 64-bit user key (parity bits included) into the sixteen 48-bit DES round subkeys.
- Presents the subkeys in encryption order (K1..K16) or decryption order (K16..K1), selected by encr_decr.
- Feeds the 16-round Feistel core; one instance per DES stage.

Parameters:
- None. Widths are fixed by the DES standard: key 64, subkey 48, half-key 28, rounds 16.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- user_key  input  64  DES key; bit 63 is DES bit 1 (MSB-first numbering)
- encr_decr  input  1  1 = encryption order, 0 = decryption order
- roundkey_1 .. roundkey_16  output  48 each  subkey for round n; bit 47 is DES bit 1

Behaviour:
- Combinational schedule:
  - PC-1 (standard 56-entry table, MSB-first indexing) maps user_key to C0 (28 bits) and D0 (28 bits). Bits 8,16,...,64 (the parity bits) are discarded.
  - For round i, C(i) and D(i) are C(i-1) and D(i-1) rotated left by the shift count s(i).
  - s(1..16) = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Cumulative shift after round 16 = 28, so C16 = C0.
  - K(i) = PC-2 applied to {C(i), D(i)} (standard 48-entry table).
- Ordering:
  - encr_decr = 1: roundkey_n = K(n).
  - encr_decr = 0: roundkey_n = K(17-n).
- Registering:
  - All 16 outputs are flops updated on every rising edge of clk from the current user_key and encr_decr.
  - No enable and no handshake; latency is exactly 1 cycle from any input change to outputs.
- Reset:
  - rst high clears all roundkey outputs to 48'h0 immediately, asynchronously, including mid-operation.
  - While rst is held, outputs stay 0.
  - After rst deasserts, the first rising edge loads valid subkeys.
- Boundary cases:
  - A change on encr_decr alone permutes the outputs on the next edge. The schedule is not recomputed.
  - Simultaneous user_key and encr_decr changes are reflected together, one edge later.
  - Parity bits never affect subkeys: keys differing only in bits 56,48,...,0 give identical outputs.
- Implementation: no state other than the 16 x 48 output registers; PC-1, PC-2 and the rotations are pure wiring.

Optional Feature:
- Macro: ROUND_KEY_PARITY_CHECK_EN.
- When defined:
  - Adds output key_parity_err (1 bit), registered with the same latency and reset value 0 as the subkeys.
  - key_parity_err = 1 when any byte of user_key has even parity. DES requires each byte to have odd parity.
  - Subkeys are still generated normally.
- When undefined: the port and its logic are absent. Subkey behaviour is identical.

Decomposition:
- Package round_key_pkg holds:
  - PC1 table (56 entries) and PC2 table (48 entries), as constant index arrays.
  - Shift schedule (16 entries).
  - Typedefs subkey_t (48-bit) and half_key_t (28-bit).
  - Constant NUM_ROUNDS = 16.
- One natural sub-module, round_key_sched: purely combinational, user_key in, K1..K16 out.
- round_key itself contains only the order mux and the output registers.

Test Plan:
- Reset: assert rst mid-run with valid outputs -> all roundkey_n = 0 immediately, before any clock edge; first edge after release loads subkeys.
- Encryption order: user_key = 64'h736865726c6f636b, encr_decr = 1, one edge ->
  - roundkey_1 = e0be66ce0b2b, roundkey_2 = e0b67635c5a2, roundkey_3 = e4d676cc0c47
  - roundkey_8 = 1f59d9386bd8, roundkey_12 = 5b2cad5f0425
  - roundkey_15 = f0be26f314a3, roundkey_16 = f0be262bf356
  - (with PARITY_CHECK_EN: key_parity_err = 1, since byte 0x65 has even parity)
- Decryption order: same key, encr_decr = 0, one edge ->
  - roundkey_1 = f0be262bf356, roundkey_5 = 5b2cad5f0425
  - roundkey_9 = 1f59d9386bd8, roundkey_16 = e0be66ce0b2b
- Standard vector: user_key = 64'h133457799BBCDFF1, encr_decr = 1 ->
  - roundkey_1 = 1b02effc7072, roundkey_16 = cb3d8b0e17f5, key_parity_err = 0
  - then toggle encr_decr to 0 -> roundkey_1 = cb3d8b0e17f5 after exactly one edge.
- Latency and parity independence:
  - Change user_key between edges -> outputs hold old values until the next rising edge.
  - Flip only bit 0 of 64'h133457799BBCDFF1 -> subkeys unchanged; key_parity_err = 1.

Source files
------------

// File: rtl/round_key_pkg.sv
// Shared constants and types for the DES key schedule: PC-1/PC-2 tables,
// per-round shift schedule and subkey/half-key types.
package round_key_pkg;

    localparam int unsigned NUM_ROUNDS = 16;
    localparam int unsigned KEY_W      = 64;
    localparam int unsigned SUBKEY_W   = 48;
    localparam int unsigned HALF_W     = 28;

    typedef logic [SUBKEY_W-1:0] subkey_t;
    typedef logic [HALF_W-1:0]   half_key_t;

    // Entries are DES bit numbers, 1 = MSB of the source vector
    localparam int unsigned PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam int unsigned SHIFTS [NUM_ROUNDS] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    // High when any byte of the key has even parity
    function automatic logic parity_err(input logic [KEY_W-1:0] key);
        logic       err;
        logic [7:0] by;
        err = 1'b0;
        for (int b = 0; b < 8; b++) begin
            by  = 8'(key >> (8 * b));
            err = err | ~(^by);
        end
        return err;
    endfunction

endpackage

// File: rtl/round_key_sched.sv
// Combinational DES key schedule: user key -> K1..K16 in encryption order.
// Pure wiring: PC-1, cumulative left rotations, PC-2.
module round_key_sched
    import round_key_pkg::*;
(
    input  logic [KEY_W-1:0] user_key,
    output subkey_t          keys [NUM_ROUNDS]
);

    half_key_t   c  [NUM_ROUNDS+1];
    half_key_t   d  [NUM_ROUNDS+1];
    logic [55:0] cd0;
    logic [55:0] cd [NUM_ROUNDS+1];

    // PC-1 drops the parity bits and splits into C0/D0
    for (genvar j = 0; j < 56; j++) begin : g_pc1
        assign cd0[55-j] = user_key[KEY_W-PC1[j]];
    end

    assign c[0] = cd0[55:28];
    assign d[0] = cd0[27:0];

    for (genvar r = 0; r < NUM_ROUNDS; r++) begin : g_rot
        if (SHIFTS[r] == 2) begin : g_two
            assign c[r+1] = {c[r][HALF_W-3:0], c[r][HALF_W-1:HALF_W-2]};
            assign d[r+1] = {d[r][HALF_W-3:0], d[r][HALF_W-1:HALF_W-2]};
        end else begin : g_one
            assign c[r+1] = {c[r][HALF_W-2:0], c[r][HALF_W-1]};
            assign d[r+1] = {d[r][HALF_W-2:0], d[r][HALF_W-1]};
        end
    end

    for (genvar r = 0; r <= NUM_ROUNDS; r++) begin : g_cat
        assign cd[r] = {c[r], d[r]};
    end

    for (genvar r = 0; r < NUM_ROUNDS; r++) begin : g_key
        for (genvar j = 0; j < SUBKEY_W; j++) begin : g_pc2
            assign keys[r][SUBKEY_W-1-j] = cd[r+1][56-PC2[j]];
        end
    end

endmodule

// File: rtl/round_key.sv
// Registered DES round-key generator with encryption/decryption ordering.
// Optional ROUND_KEY_PARITY_CHECK_EN adds a registered key_parity_err output.
module round_key
    import round_key_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [KEY_W-1:0]  user_key,
    input  logic              encr_decr,
    output logic [47:0]       roundkey_1,
    output logic [47:0]       roundkey_2,
    output logic [47:0]       roundkey_3,
    output logic [47:0]       roundkey_4,
    output logic [47:0]       roundkey_5,
    output logic [47:0]       roundkey_6,
    output logic [47:0]       roundkey_7,
    output logic [47:0]       roundkey_8,
    output logic [47:0]       roundkey_9,
    output logic [47:0]       roundkey_10,
    output logic [47:0]       roundkey_11,
    output logic [47:0]       roundkey_12,
    output logic [47:0]       roundkey_13,
    output logic [47:0]       roundkey_14,
    output logic [47:0]       roundkey_15,
    output logic [47:0]       roundkey_16
`ifdef ROUND_KEY_PARITY_CHECK_EN
    ,
    output logic              key_parity_err
`endif
);

    subkey_t keys    [NUM_ROUNDS];
    subkey_t ordered [NUM_ROUNDS];

    round_key_sched u_sched (
        .user_key (user_key),
        .keys     (keys)
    );

    // Decryption uses the same schedule, reversed
    for (genvar i = 0; i < NUM_ROUNDS; i++) begin : g_order
        assign ordered[i] = encr_decr ? keys[i] : keys[NUM_ROUNDS-1-i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            roundkey_1  <= '0;
            roundkey_2  <= '0;
            roundkey_3  <= '0;
            roundkey_4  <= '0;
            roundkey_5  <= '0;
            roundkey_6  <= '0;
            roundkey_7  <= '0;
            roundkey_8  <= '0;
            roundkey_9  <= '0;
            roundkey_10 <= '0;
            roundkey_11 <= '0;
            roundkey_12 <= '0;
            roundkey_13 <= '0;
            roundkey_14 <= '0;
            roundkey_15 <= '0;
            roundkey_16 <= '0;
        end else begin
            roundkey_1  <= ordered[0];
            roundkey_2  <= ordered[1];
            roundkey_3  <= ordered[2];
            roundkey_4  <= ordered[3];
            roundkey_5  <= ordered[4];
            roundkey_6  <= ordered[5];
            roundkey_7  <= ordered[6];
            roundkey_8  <= ordered[7];
            roundkey_9  <= ordered[8];
            roundkey_10 <= ordered[9];
            roundkey_11 <= ordered[10];
            roundkey_12 <= ordered[11];
            roundkey_13 <= ordered[12];
            roundkey_14 <= ordered[13];
            roundkey_15 <= ordered[14];
            roundkey_16 <= ordered[15];
        end
    end

`ifdef ROUND_KEY_PARITY_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_parity_err <= 1'b0;
        end else begin
            key_parity_err <= parity_err(user_key);
        end
    end
`endif

endmodule

// File: tb/tb_round_key.sv
// Directed self-checking bench for round_key with hand-computed DES subkeys.
// Parity-error checks are compiled in only with ROUND_KEY_PARITY_CHECK_EN.
module tb_round_key;

    logic        clk;
    logic        rst;
    logic [63:0] user_key;
    logic        encr_decr;
    logic [47:0] rk [1:16];
`ifdef ROUND_KEY_PARITY_CHECK_EN
    logic        key_parity_err;
`endif

    int checks;
    int failures;

    localparam logic [63:0] KEY_SH  = 64'h736865726c6f636b;
    localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;

    round_key dut (
        .clk         (clk),
        .rst         (rst),
        .user_key    (user_key),
        .encr_decr   (encr_decr),
        .roundkey_1  (rk[1]),
        .roundkey_2  (rk[2]),
        .roundkey_3  (rk[3]),
        .roundkey_4  (rk[4]),
        .roundkey_5  (rk[5]),
        .roundkey_6  (rk[6]),
        .roundkey_7  (rk[7]),
        .roundkey_8  (rk[8]),
        .roundkey_9  (rk[9]),
        .roundkey_10 (rk[10]),
        .roundkey_11 (rk[11]),
        .roundkey_12 (rk[12]),
        .roundkey_13 (rk[13]),
        .roundkey_14 (rk[14]),
        .roundkey_15 (rk[15]),
        .roundkey_16 (rk[16])
`ifdef ROUND_KEY_PARITY_CHECK_EN
        ,
        .key_parity_err (key_parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        user_key  = 64'h0;
        encr_decr = 1'b1;

        step();
        step();
        check("reset_rk1",  64'(rk[1]),  64'h0);
        check("reset_rk16", 64'(rk[16]), 64'h0);

        rst      = 1'b0;
        user_key = KEY_SH;
        step();
        check("enc_rk1",  64'(rk[1]),  64'he0be66ce0b2b);
        check("enc_rk2",  64'(rk[2]),  64'he0b67635c5a2);
        check("enc_rk3",  64'(rk[3]),  64'he4d676cc0c47);
        check("enc_rk8",  64'(rk[8]),  64'h1f59d9386bd8);
        check("enc_rk12", 64'(rk[12]), 64'h5b2cad5f0425);
        check("enc_rk15", 64'(rk[15]), 64'hf0be26f314a3);
        check("enc_rk16", 64'(rk[16]), 64'hf0be262bf356);
`ifdef ROUND_KEY_PARITY_CHECK_EN
        check("enc_perr", 64'(key_parity_err), 64'h1);
`endif

        encr_decr = 1'b0;
        step();
        check("dec_rk1",  64'(rk[1]),  64'hf0be262bf356);
        check("dec_rk5",  64'(rk[5]),  64'h5b2cad5f0425);
        check("dec_rk9",  64'(rk[9]),  64'h1f59d9386bd8);
        check("dec_rk16", 64'(rk[16]), 64'he0be66ce0b2b);

        // Inputs change mid-cycle; outputs must hold until the next edge
        user_key  = KEY_STD;
        encr_decr = 1'b1;
        #2;
        check("hold_rk1", 64'(rk[1]), 64'hf0be262bf356);
        step();
        check("std_rk1",  64'(rk[1]),  64'h1b02effc7072);
        check("std_rk16", 64'(rk[16]), 64'hcb3d8b0e17f5);
`ifdef ROUND_KEY_PARITY_CHECK_EN
        check("std_perr", 64'(key_parity_err), 64'h0);
`endif

        encr_decr = 1'b0;
        step();
        check("tog_rk1",  64'(rk[1]),  64'hcb3d8b0e17f5);
        check("tog_rk16", 64'(rk[16]), 64'h1b02effc7072);

        encr_decr = 1'b1;
        user_key  = KEY_STD ^ 64'h1;
        step();
        check("par_rk1",  64'(rk[1]),  64'h1b02effc7072);
        check("par_rk16", 64'(rk[16]), 64'hcb3d8b0e17f5);
`ifdef ROUND_KEY_PARITY_CHECK_EN
        check("par_perr", 64'(key_parity_err), 64'h1);
`endif

        // Asynchronous reset well before the next edge
        #2;
        rst = 1'b1;
        #1;
        check("arst_rk1", 64'(rk[1]), 64'h0);
        check("arst_rk8", 64'(rk[8]), 64'h0);
        step();
        check("hold_rst_rk16", 64'(rk[16]), 64'h0);
        rst = 1'b0;
        step();
        check("post_rst_rk1", 64'(rk[1]), 64'h1b02effc7072);

        // Key and order change together
        user_key  = KEY_SH;
        encr_decr = 1'b0;
        step();
        check("sim_rk1",  64'(rk[1]),  64'hf0be262bf356);
        check("sim_rk16", 64'(rk[16]), 64'he0be66ce0b2b);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
